// File: rtl/sram_zbt_responder.sv
// sram_zbt_responder
//
// SRAM-side responder for the arbiter request interface. It accepts one read
// or byte-masked write per sram_clock cycle and drives a pipelined ZBT SRAM.
// Read data comes back a fixed 3 cycles after acceptance, in request order.
// Writes produce no response.
//
// Ports:
//   sram_clock, reset          sole clock (rising edge); synchronous active-high reset
//   sram_addr_valid/ready      request handshake (see below)
//   sram_addr [17:0]           word address
//   sram_data_in [31:0]        write data (ignored for reads)
//   sram_write_mask [3:0]      byte enables; 4'b0000 means read
//   sram_data_out [31:0]       read data, held while valid is low
//   sram_data_out_valid        one-cycle pulse per read
//   pin_*                      registered ZBT SRAM pins (control lines active low)
//   pin_dq_out/oe/in           split DQ bus; the tristate lives at chip top
//
// Handshake: a request transfers in every cycle where sram_addr_valid and
// sram_ready are both 1. sram_ready is low only during the power-up wait after
// reset; afterwards it stays high, so there is no back-pressure and any
// read/write mix can issue on consecutive cycles.
//
// Pipeline (request accepted in cycle T):
//   T+1  S1 issue:   address/control pins loaded from the request
//   T+2  S2 data:    writes drive DQ, reads enable SRAM outputs
//   T+3  S3 capture: read data registered from pin_dq_in onto the outputs
module sram_zbt_responder #(
  parameter int INIT_CYCLES = 16
) (
  input  logic        sram_clock,
  input  logic        reset,
  input  logic        sram_addr_valid,
  output logic        sram_ready,
  input  logic [17:0] sram_addr,
  input  logic [31:0] sram_data_in,
  input  logic [3:0]  sram_write_mask,
  output logic [31:0] sram_data_out,
  output logic        sram_data_out_valid,
  output logic [17:0] pin_addr,
  output logic        pin_ce_l,
  output logic        pin_we_l,
  output logic [3:0]  pin_bw_l,
  output logic        pin_oe_l,
  output logic        pin_adv_ld_l,
  output logic [31:0] pin_dq_out,
  output logic        pin_dq_oe,
  input  logic [31:0] pin_dq_in
);

  localparam int CW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [CW-1:0] INIT_LAST = CW'(INIT_CYCLES - 1);

  logic [CW-1:0] init_count;

  // S1 stage: request issued on the pins this cycle
  logic        s1_valid;
  logic        s1_write;
  logic [31:0] s1_data;

  // S2 stage: only reads need to travel on to the capture stage
  logic        s2_read;

  logic accept;
  logic is_write;

  assign accept   = sram_addr_valid && sram_ready;
  assign is_write = |sram_write_mask;

  // Every access carries its own address, so the burst counter is never used.
  assign pin_adv_ld_l = 1'b0;

  always_ff @(posedge sram_clock) begin
    if (reset) begin
      init_count          <= '0;
      sram_ready          <= 1'b0;
      s1_valid            <= 1'b0;
      s1_write            <= 1'b0;
      s1_data             <= '0;
      s2_read             <= 1'b0;
      sram_data_out       <= '0;
      sram_data_out_valid <= 1'b0;
      pin_addr            <= '0;
      pin_ce_l            <= 1'b1;
      pin_we_l            <= 1'b1;
      pin_bw_l            <= 4'hF;
      pin_oe_l            <= 1'b1;
      pin_dq_oe           <= 1'b0;
      pin_dq_out          <= '0;
    end else begin
      // Power-up wait: ready rises the cycle after the count reaches its last
      // value and then stays up until the next reset.
      if (!sram_ready) begin
        if (init_count == INIT_LAST) begin
          sram_ready <= 1'b1;
        end else begin
          init_count <= init_count + 1'b1;
        end
      end

      // S1: issue. pin_addr only moves on an accepted request.
      s1_valid <= accept;
      s1_write <= accept && is_write;
      if (accept && is_write) begin
        s1_data <= sram_data_in;
      end
      if (accept) begin
        pin_addr <= sram_addr;
      end
      pin_ce_l <= !accept;
      pin_we_l <= !(accept && is_write);
      pin_bw_l <= (accept && is_write) ? ~sram_write_mask : 4'hF;

      // S2: data phase. A read and a write never share this stage, so DQ
      // drive and SRAM output enable can never overlap.
      pin_dq_oe <= s1_write;
      if (s1_write) begin
        pin_dq_out <= s1_data;
      end
      pin_oe_l <= !(s1_valid && !s1_write);
      s2_read  <= s1_valid && !s1_write;

      // S3: capture what the SRAM drove during the data phase.
      sram_data_out_valid <= s2_read;
      if (s2_read) begin
        sram_data_out <= pin_dq_in;
      end
    end
  end

endmodule
